// File: rtl/lc3_fetch_stage.sv
`default_nettype none
// lc3_fetch_stage - LC3 fetch: PC, one-outstanding imem reads, PC/instr FIFO toward decode.
// Rev 1.0. Optional counters perf_fetched/perf_redirects under LC3_FETCH_PERF_EN.
module lc3_fetch_stage #(
   parameter logic [15:0] PC_RESET   = 16'h3000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   input  logic        br_taken,
   input  logic [15:0] taddr,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [15:0] dec_instr,
   output logic [15:0] dec_pc,
   output logic [15:0] dec_npc
`ifdef LC3_FETCH_PERF_EN
   ,
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_redirects
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [15:0]        pc, pc_nxt;
   logic               withdraw;

   logic [15:0]        fifo_instr [FIFO_DEPTH];
   logic [15:0]        fifo_pc    [FIFO_DEPTH];
   logic [15:0]        fifo_npc   [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_after;

   logic               accept, push, pop, has_room;

   assign accept      = imem_req & imem_gnt;
   assign push        = (state == S_WAIT) & imem_rvalid & ~br_taken;
   assign pop         = dec_valid & dec_ready & ~br_taken;
   assign count_after = count + CNT_W'(push) - CNT_W'(pop);
   assign has_room    = count_after < CNT_W'(FIFO_DEPTH);

   // A redirect in REQ without a grant drops the request for one cycle so the
   // address never changes underneath an asserted request.
   assign imem_req  = (state == S_REQ) & ~withdraw & reset_n;
   assign imem_addr = pc;

   assign dec_valid = (count != '0);
   assign dec_instr = fifo_instr[rd_ptr];
   assign dec_pc    = fifo_pc[rd_ptr];
   assign dec_npc   = fifo_npc[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_REQ;
         pc       <= PC_RESET;
         withdraw <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         withdraw <= br_taken & (state == S_REQ) & ~accept;
      end
   end

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      case (state)
         S_REQ: begin
            if (br_taken)
               state_nxt = accept ? S_DROP : S_REQ;
            else if (accept)
               state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (br_taken) begin
                  state_nxt = S_REQ;
               end else begin
                  pc_nxt    = pc + 16'd1;
                  state_nxt = has_room ? S_REQ : S_HOLD;
               end
            end else if (br_taken) begin
               state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (br_taken || has_room)
               state_nxt = S_REQ;
         end
         S_DROP: begin
            if (imem_rvalid)
               state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase
      if (br_taken)
         pc_nxt = taddr;
   end

   // A redirect empties the buffer and overrides any push/pop in the same cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_instr[i] <= '0;
            fifo_pc[i]    <= '0;
            fifo_npc[i]   <= '0;
         end
      end else if (br_taken) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= pc;
            fifo_npc[wr_ptr]   <= pc + 16'd1;
            wr_ptr             <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_after;
      end
   end

`ifdef LC3_FETCH_PERF_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
      end else begin
         if (push && perf_fetched != 16'hFFFF)
            perf_fetched <= perf_fetched + 16'd1;
         if (br_taken && perf_redirects != 16'hFFFF)
            perf_redirects <= perf_redirects + 16'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lc3_fetch_stage.sv
`default_nettype none
// tb_lc3_fetch_stage - scoreboard bench: transaction-level fetch model vs. decode-side output.
module tb_lc3_fetch_stage;

   localparam logic [15:0] PC_RST = 16'h3000;
   localparam int          DEPTH  = 2;

   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset_n;
   logic        imem_req, imem_gnt, imem_rvalid, br_taken, dec_valid, dec_ready;
   logic [15:0] imem_addr, imem_rdata, taddr, dec_instr, dec_pc, dec_npc;

   // second instance: PC_RESET at the top of memory, memory always ready
   logic        w_req, w_valid;
   logic [15:0] w_addr, w_instr, w_pc, w_npc;
   logic        w_one  = 1'b1;
   logic        w_zero = 1'b0;
   logic [15:0] w_data = 16'hBEEF;
   logic [15:0] w_ta   = 16'h0000;

`ifdef LC3_FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_redirects, w_pf, w_pr;
`endif

   lc3_fetch_stage #(.PC_RESET(PC_RST), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .br_taken(br_taken), .taddr(taddr),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_npc(dec_npc)
`ifdef LC3_FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
   );

   lc3_fetch_stage #(.PC_RESET(16'hFFFF), .FIFO_DEPTH(DEPTH)) dut_wrap (
      .clock(clock), .reset_n(reset_n),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_one),
      .imem_rvalid(w_one), .imem_rdata(w_data),
      .br_taken(w_zero), .taddr(w_ta),
      .dec_valid(w_valid), .dec_ready(w_one),
      .dec_instr(w_instr), .dec_pc(w_pc), .dec_npc(w_npc)
`ifdef LC3_FETCH_PERF_EN
      , .perf_fetched(w_pf), .perf_redirects(w_pr)
`endif
   );

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic [15:0] npc;
   } entry_t;

   entry_t      sb_q[$];
   int          checks = 0;
   int          passed = 0;

   // reference model: next address to be fetched and the one outstanding read
   logic [15:0] exp_pc;
   logic        outstanding, cancelled;
   logic [15:0] out_pc, mem_addr;
   int          pushes_m, redirects_m;
   logic        last_gnt, last_rv;
   logic [15:0] last_gnt_addr;
   logic        mon_en = 1'b0;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'h2234;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      sb_q.delete();
      exp_pc      = PC_RST;
      outstanding = 1'b0;
      cancelled   = 1'b0;
      pushes_m    = 0;
      redirects_m = 0;
   endtask

   // Drive one cycle of memory/branch/decode stimulus, update the model, advance.
   task automatic drive_cycle(input int gp, input int rp, input int bp, input int dp,
                              input logic fb, input logic [15:0] fta);
      logic g, rv, br, rdy;
      logic [15:0] ta;
      entry_t e;
      g   = imem_req && !outstanding && (int'($urandom_range(99)) < gp);
      rv  = outstanding && (int'($urandom_range(99)) < rp);
      if (!outstanding && bp > 0 && $urandom_range(99) < 5) rv = 1'b1;
      br  = fb || (int'($urandom_range(99)) < bp);
      ta  = fb ? fta : 16'($urandom);
      rdy = int'($urandom_range(99)) < dp;

      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = outstanding ? mem_word(mem_addr) : 16'($urandom);
      br_taken    = br;
      taddr       = ta;
      dec_ready   = rdy;

      last_gnt = g;
      last_rv  = rv && outstanding;
      if (rv && outstanding) begin
         outstanding = 1'b0;
         if (!cancelled && !br) begin
            e.pc    = out_pc;
            e.instr = mem_word(out_pc);
            e.npc   = out_pc + 16'd1;
            sb_q.push_back(e);
            exp_pc  = out_pc + 16'd1;
            pushes_m++;
         end
      end
      if (g) begin
         chk("fetch_addr", imem_addr, exp_pc);
         last_gnt_addr = imem_addr;
         mem_addr      = imem_addr;
         out_pc        = exp_pc;
         outstanding   = 1'b1;
         cancelled     = 1'b0;
      end
      if (br) begin
         sb_q.delete();
         exp_pc = ta;
         if (outstanding) cancelled = 1'b1;
         redirects_m++;
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: compares each accepted decode entry with the scoreboard head.
   logic        prev_br, prev_req, prev_gnt;
   logic [15:0] prev_addr;
   always @(negedge clock) begin
      entry_t e;
      if (mon_en && reset_n) begin
         if (prev_br) chk("flush_valid", {15'd0, dec_valid}, 16'd0);
         if (prev_req && !prev_gnt && imem_req) chk("addr_stable", imem_addr, prev_addr);
         if (dec_valid && dec_ready && !br_taken) begin
            if (sb_q.size() == 0) begin
               checks++;
               $display("FAIL pop_empty: got pc %h, expected no entry", dec_pc);
            end else begin
               e = sb_q.pop_front();
               chk("dec_instr", dec_instr, e.instr);
               chk("dec_pc", dec_pc, e.pc);
               chk("dec_npc", dec_npc, e.npc);
            end
         end
         prev_br   = br_taken;
         prev_req  = imem_req;
         prev_gnt  = imem_gnt;
         prev_addr = imem_addr;
      end else begin
         prev_br  = 1'b0;
         prev_req = 1'b0;
         prev_gnt = 1'b0;
      end
   end

   task automatic check_reset_outputs();
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_addr", imem_addr, PC_RST);
      chk("rst_valid", {15'd0, dec_valid}, 16'd0);
      chk("rst_instr", dec_instr, 16'd0);
      chk("rst_pc", dec_pc, 16'd0);
      chk("rst_npc", dec_npc, 16'd0);
`ifdef LC3_FETCH_PERF_EN
      chk("rst_perf_fetched", perf_fetched, 16'd0);
      chk("rst_perf_redirects", perf_redirects, 16'd0);
`endif
   endtask

   task automatic wait_grant(input string name);
      int n;
      n = 0;
      last_gnt = 1'b0;
      while (!last_gnt && n < 50) begin
         drive_cycle(100, 100, 0, 100, 1'b0, 16'h0);
         n++;
      end
      if (!last_gnt) begin
         checks++;
         $display("FAIL %s: got no grant in %0d cycles, expected a grant", name, n);
      end
   endtask

   initial begin
      int idle;
      reset_n     = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0;
      br_taken    = 1'b0;
      taddr       = 16'h0;
      dec_ready   = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check_reset_outputs();
      reset_n = 1'b1;
      #1;
      chk("first_req", {15'd0, imem_req}, 16'd1);
      chk("first_addr", imem_addr, PC_RST);
      mon_en = 1'b1;

      // single fetch with immediate gnt/rvalid
      drive_cycle(100, 100, 0, 100, 1'b0, 16'h0);
      drive_cycle(100, 100, 0, 100, 1'b0, 16'h0);
      chk("t1_valid", {15'd0, dec_valid}, 16'd1);
      chk("t1_instr", dec_instr, 16'h1234);
      chk("t1_pc", dec_pc, 16'h3000);
      chk("t1_npc", dec_npc, 16'h3001);
      chk("t1_next_req", {15'd0, imem_req}, 16'd1);
      chk("t1_next_addr", imem_addr, 16'h3001);
      chk("wrap_addr", w_addr, 16'h0000);
      chk("wrap_pc", w_pc, 16'hFFFF);
      chk("wrap_npc", w_npc, 16'h0000);

      // reset in the middle of an outstanding read; a stray rvalid afterwards is ignored
      drive_cycle(100, 0, 0, 100, 1'b0, 16'h0);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs();
      @(posedge clock);
      #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
      dec_ready   = 1'b0;
      reset_n     = 1'b1;
      @(posedge clock);
      #1;
      chk("stray_valid", {15'd0, dec_valid}, 16'd0);
      chk("stray_req", {15'd0, imem_req}, 16'd1);
      chk("stray_addr", imem_addr, PC_RST);

      // decode stalled: buffer fills, fetch holds off
      repeat (8) drive_cycle(100, 100, 0, 0, 1'b0, 16'h0);
      chk("hold_req", {15'd0, imem_req}, 16'd0);
      chk("hold_valid", {15'd0, dec_valid}, 16'd1);
      chk("hold_head", dec_pc, 16'h3000);
      wait_grant("resume");
      chk("resume_addr", last_gnt_addr, 16'h3002);

      // redirect while waiting: the returning word must be dropped
      wait_grant("t3_grant");
      drive_cycle(0, 0, 0, 100, 1'b1, 16'h4000);
      chk("t3_drop_req", {15'd0, imem_req}, 16'd0);
      drive_cycle(0, 100, 0, 100, 1'b0, 16'h0);
      chk("t3_req", {15'd0, imem_req}, 16'd1);
      chk("t3_addr", imem_addr, 16'h4000);
      chk("t3_valid", {15'd0, dec_valid}, 16'd0);

      // redirect coincident with rvalid
      wait_grant("t4_grant");
      drive_cycle(0, 100, 0, 100, 1'b1, 16'h5000);
      chk("t4_valid", {15'd0, dec_valid}, 16'd0);
      chk("t4_req", {15'd0, imem_req}, 16'd1);
      chk("t4_addr", imem_addr, 16'h5000);

      // randomized traffic
      idle = 0;
      for (int i = 0; i < 3000; i++) begin
         drive_cycle(70, 60, 6, 70, 1'b0, 16'h0);
         if (last_gnt || last_rv) idle = 0;
         else idle++;
         if (idle > 100) begin
            checks++;
            $display("FAIL liveness: got %0d idle cycles, expected at most 100", idle);
            break;
         end
      end
      repeat (12) drive_cycle(0, 100, 0, 100, 1'b0, 16'h0);
      chk("sb_drained", 16'(sb_q.size()), 16'd0);
`ifdef LC3_FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 16'(pushes_m));
      chk("perf_redirects", perf_redirects, 16'(redirects_m));
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
